// File: rtl/pwm_reg_scheduler_if.sv
// pwm_reg_scheduler_if: I2C target register-access handshake (request held until one-cycle ack)
interface pwm_reg_scheduler_if;
    logic       req;
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic       ack;
    logic [7:0] rdata;
    modport master (output req, we, addr, wdata, input ack, rdata);
    modport slave  (input req, we, addr, wdata, output ack, rdata);
endinterface

// File: rtl/pwm_reg_scheduler.sv
// pwm_reg_scheduler: arbitrates the PWM register RAM port between I2C accesses and 4-byte channel refresh bursts
module pwm_reg_scheduler #(
    parameter int         NUM_CH    = 16,
    parameter logic [7:0] BASE_ADDR = 8'h06
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    pwm_reg_scheduler_if.slave  i2c,
    input  logic                refresh_start_i,
    output logic                refresh_busy_o,
    output logic                ch_load_o,
    output logic [3:0]          ch_idx_o,
    output logic [12:0]         ch_on_o,
    output logic [12:0]         ch_off_o,
    output logic                ram_en_o,
    output logic                ram_we_o,
    output logic [7:0]          ram_addr_o,
    output logic [7:0]          ram_wdata_o,
    input  logic [7:0]          ram_rdata_i
);
    // REF_Bk encodes the burst byte index in its low two bits; all non-arbitrating states advance by +1
    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        I2C_WR     = 3'd1,
        I2C_RD     = 3'd2,
        I2C_RD_CAP = 3'd3,
        REF_B0     = 3'd4,
        REF_B1     = 3'd5,
        REF_B2     = 3'd6,
        REF_B3     = 3'd7
    } state_e;

    state_e      st_q, st_d;
    logic        lg_q, lg_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        more_q, more_d;
    logic        scan_q, scan_d;
    logic        ram_en_q, ram_en_d, ram_we_q, ram_we_d;
    logic [7:0]  ram_addr_q, ram_addr_d, ram_wdata_q, ram_wdata_d;
    logic        tag_v_q;
    logic [1:0]  tag_b_q;
    logic [3:0]  tag_idx_q;
    logic [7:0]  on_l_q, off_l_q;
    logic [4:0]  on_h_q;
    logic        ch_load_q;
    logic [3:0]  ch_idx_q;
    logic [12:0] ch_on_q, ch_off_q;
    logic        ack_q;
    logic [7:0]  rdata_q;

    logic last_ch, in_ack, arb, i2c_cand, new_scan, ref_cand, pick_i2c, pick_ref;

    assign last_ch  = cnt_q == 4'(NUM_CH - 1);
    assign in_ack   = st_q == I2C_WR || st_q == I2C_RD_CAP;
    assign arb      = st_q == IDLE || in_ack || st_q == REF_B3;
    assign i2c_cand = i2c.req && !in_ack;
    assign new_scan = refresh_start_i && !scan_q;
    assign ref_cand = (more_q && !(st_q == REF_B3 && last_ch)) || new_scan;
    assign pick_i2c = i2c_cand && (!ref_cand || !lg_q);
    assign pick_ref = ref_cand && !pick_i2c;

    // Next state, grant flag, scan bookkeeping and the registered RAM command for the next cycle
    always_comb begin
        st_d        = arb ? (pick_i2c ? (i2c.we ? I2C_WR : I2C_RD) : pick_ref ? REF_B0 : IDLE)
                          : state_e'(st_q + 3'd1);
        lg_d        = arb && (pick_i2c || pick_ref) ? pick_i2c : lg_q;
        cnt_d       = st_q == REF_B3 ? (last_ch ? 4'd0 : cnt_q + 4'd1) : cnt_q;
        more_d      = new_scan || (more_q && !(st_q == REF_B3 && last_ch));
        scan_d      = scan_q ? !(ch_load_q && ch_idx_q == 4'(NUM_CH - 1)) : refresh_start_i;
        ram_en_d    = st_d != IDLE && st_d != I2C_RD_CAP;
        ram_we_d    = st_d == I2C_WR;
        ram_addr_d  = st_d[2] ? BASE_ADDR + {2'b00, cnt_d, 2'b00} + {6'd0, st_d[1:0]} : i2c.addr;
        ram_wdata_d = st_d == I2C_WR ? i2c.wdata : 8'd0;
    end

    // Control state and RAM command registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            st_q        <= IDLE;
            lg_q        <= 1'b0;
            cnt_q       <= 4'd0;
            more_q      <= 1'b0;
            scan_q      <= 1'b0;
            ram_en_q    <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= 8'd0;
            ram_wdata_q <= 8'd0;
        end else begin
            st_q        <= st_d;
            lg_q        <= lg_d;
            cnt_q       <= cnt_d;
            more_q      <= more_d;
            scan_q      <= scan_d;
            ram_en_q    <= ram_en_d;
            ram_we_q    <= ram_we_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
        end
    end

    // Capture read data one cycle after each strobe; assemble and publish a channel after its OFF_H byte
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tag_v_q   <= 1'b0;
            tag_b_q   <= 2'd0;
            tag_idx_q <= 4'd0;
            on_l_q    <= 8'd0;
            on_h_q    <= 5'd0;
            off_l_q   <= 8'd0;
            ch_load_q <= 1'b0;
            ch_idx_q  <= 4'd0;
            ch_on_q   <= 13'd0;
            ch_off_q  <= 13'd0;
            ack_q     <= 1'b0;
            rdata_q   <= 8'd0;
        end else begin
            tag_v_q   <= st_q[2];
            tag_b_q   <= st_q[1:0];
            tag_idx_q <= cnt_q;
            if (tag_v_q && tag_b_q == 2'd0) on_l_q <= ram_rdata_i;
            if (tag_v_q && tag_b_q == 2'd1) on_h_q <= ram_rdata_i[4:0];
            if (tag_v_q && tag_b_q == 2'd2) off_l_q <= ram_rdata_i;
            ch_load_q <= tag_v_q && tag_b_q == 2'd3;
            if (tag_v_q && tag_b_q == 2'd3) begin
                ch_idx_q <= tag_idx_q;
                ch_on_q  <= {on_h_q, on_l_q};
                ch_off_q <= {ram_rdata_i[4:0], off_l_q};
            end
            ack_q <= in_ack;
            if (st_q == I2C_RD_CAP) rdata_q <= ram_rdata_i;
        end
    end

    assign refresh_busy_o = scan_q;
    assign ch_load_o      = ch_load_q;
    assign ch_idx_o       = ch_idx_q;
    assign ch_on_o        = ch_on_q;
    assign ch_off_o       = ch_off_q;
    assign ram_en_o       = ram_en_q;
    assign ram_we_o       = ram_we_q;
    assign ram_addr_o     = ram_addr_q;
    assign ram_wdata_o    = ram_wdata_q;
    assign i2c.ack        = ack_q;
    assign i2c.rdata      = rdata_q;
endmodule

// File: tb/tb_pwm_reg_scheduler.sv
// tb_pwm_reg_scheduler: directed checks of refresh scans, I2C access timing, contention and reset
module tb_pwm_reg_scheduler;
    localparam int         NUM_CH = 16;
    localparam logic [7:0] BASE   = 8'h06;

    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    logic        refresh_start_i = 1'b0;
    logic        refresh_busy_o, ch_load_o;
    logic [3:0]  ch_idx_o;
    logic [12:0] ch_on_o, ch_off_o;
    logic        ram_en_o, ram_we_o;
    logic [7:0]  ram_addr_o, ram_wdata_o;
    logic [7:0]  ram_rdata_i = 8'd0;

    pwm_reg_scheduler_if i2c_bus();

    pwm_reg_scheduler #(.NUM_CH(NUM_CH), .BASE_ADDR(BASE)) dut (
        .clk_i(clk),
        .rst_ni(rst_ni),
        .i2c(i2c_bus),
        .refresh_start_i(refresh_start_i),
        .refresh_busy_o(refresh_busy_o),
        .ch_load_o(ch_load_o),
        .ch_idx_o(ch_idx_o),
        .ch_on_o(ch_on_o),
        .ch_off_o(ch_off_o),
        .ram_en_o(ram_en_o),
        .ram_we_o(ram_we_o),
        .ram_addr_o(ram_addr_o),
        .ram_wdata_o(ram_wdata_o),
        .ram_rdata_i(ram_rdata_i)
    );

    int n_checks = 0, n_errors = 0, cyc = 0;
    logic [7:0] mem [256];
    bit loaded = 1'b0;
    int n_ld = 0, n_st = 0, busy_rise = 0, busy_fall = 0;
    bit bprev = 1'b0;
    int          ld_cyc  [1024];
    logic [3:0]  ld_idx  [1024];
    logic [12:0] ld_on   [1024];
    logic [12:0] ld_off  [1024];
    int          st_cyc  [1024];
    logic [7:0]  st_addr [1024];
    logic [7:0]  st_wd   [1024];
    logic        st_we   [1024];

    always #5 clk = ~clk;

    // Free-running cycle number: cycle N spans posedge N to posedge N+1
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] init_val(input int a);
        case (a)
            6:  return 8'h34;
            7:  return 8'h12;
            8:  return 8'h78;
            9:  return 8'h16;
            18: return 8'h5A;
            19: return 8'hFF;
            20: return 8'hC3;
            21: return 8'hE0;
            default: return 8'(a);
        endcase
    endfunction

    // Synchronous single-port RAM, preloaded on the first edge, read data one cycle after the strobe
    always @(posedge clk) begin
        if (!loaded) begin
            for (int i = 0; i < 256; i++) mem[i] <= init_val(i);
            loaded <= 1'b1;
        end else if (ram_en_o) begin
            if (ram_we_o) mem[ram_addr_o] <= ram_wdata_o;
            ram_rdata_i <= mem[ram_addr_o];
        end
    end

    // Log channel loads, RAM strobes and busy edges with their cycle numbers
    always @(negedge clk) begin
        if (ch_load_o) begin
            ld_cyc[n_ld] = cyc;
            ld_idx[n_ld] = ch_idx_o;
            ld_on[n_ld]  = ch_on_o;
            ld_off[n_ld] = ch_off_o;
            n_ld++;
        end
        if (ram_en_o) begin
            st_cyc[n_st]  = cyc;
            st_addr[n_st] = ram_addr_o;
            st_wd[n_st]   = ram_wdata_o;
            st_we[n_st]   = ram_we_o;
            n_st++;
        end
        if (refresh_busy_o && !bprev) busy_rise = cyc;
        if (!refresh_busy_o && bprev) busy_fall = cyc;
        bprev = refresh_busy_o;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic start_scan(output int s);
        s = cyc;
        refresh_start_i = 1'b1;
        @(negedge clk);
        refresh_start_i = 1'b0;
    endtask

    task automatic wait_scan();
        int n = 0;
        while (refresh_busy_o && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("scan_done", 64'(n < 300), 64'd1);
        @(negedge clk);
    endtask

    task automatic i2c_xfer(input logic we, input logic [7:0] a, input logic [7:0] d,
                            output int lat, output logic [7:0] rd);
        int t0 = cyc;
        i2c_bus.req   = 1'b1;
        i2c_bus.we    = we;
        i2c_bus.addr  = a;
        i2c_bus.wdata = d;
        lat = -1;
        rd  = 8'd0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (i2c_bus.ack) begin
                lat = cyc - t0;
                rd  = i2c_bus.rdata;
                break;
            end
        end
        i2c_bus.req = 1'b0;
        @(negedge clk);
        check("ack_pulse", 64'(i2c_bus.ack), 64'd0);
    endtask

    // dly = RAM cycles stolen by one I2C access inserted after the first burst
    task automatic check_scan(input int s, input int l0, input int s0, input int dly);
        logic [7:0] lo, hi, ol, oh;
        int j, ins;
        check("nloads", 64'(n_ld - l0), 64'd16);
        check("busy_rise", 64'(busy_rise), 64'(s + 1));
        check("busy_fall", 64'(busy_fall), 64'(s + 67 + dly));
        for (int k = 0; k < NUM_CH; k++) begin
            j   = l0 + k;
            ins = k > 0 ? dly : 0;
            lo  = init_val(6 + 4 * k);
            hi  = init_val(7 + 4 * k);
            ol  = init_val(8 + 4 * k);
            oh  = init_val(9 + 4 * k);
            check($sformatf("ld_idx[%0d]", k), 64'(ld_idx[j]), 64'(k));
            check($sformatf("ld_cyc[%0d]", k), 64'(ld_cyc[j]), 64'(s + 6 + 4 * k + ins));
            check($sformatf("ld_on[%0d]", k), 64'(ld_on[j]), 64'({hi[4:0], lo}));
            check($sformatf("ld_off[%0d]", k), 64'(ld_off[j]), 64'({oh[4:0], ol}));
        end
        for (int k = 0; k < 4 * NUM_CH; k++) begin
            ins = k >= 4 ? dly : 0;
            j   = s0 + k + ins;
            check($sformatf("rd_addr[%0d]", k), 64'(st_addr[j]), 64'(BASE + 8'(k)));
            check($sformatf("rd_cyc[%0d]", k), 64'(st_cyc[j]), 64'(s + 1 + k + ins));
            check($sformatf("rd_we[%0d]", k), 64'(st_we[j]), 64'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int s, l0, s0, t0, lat, n1;
        logic [7:0] rd;
        i2c_bus.req   = 1'b0;
        i2c_bus.we    = 1'b0;
        i2c_bus.addr  = 8'd0;
        i2c_bus.wdata = 8'd0;
        repeat (3) @(negedge clk);
        check("rst_outs", 64'({i2c_bus.ack, i2c_bus.rdata, refresh_busy_o, ch_load_o, ch_idx_o, ch_on_o,
                               ch_off_o, ram_en_o, ram_we_o, ram_addr_o, ram_wdata_o}), 64'd0);
        rst_ni = 1'b1;
        repeat (2) @(negedge clk);

        l0 = n_ld;
        s0 = n_st;
        start_scan(s);
        repeat (19) @(negedge clk);
        refresh_start_i = 1'b1;
        @(negedge clk);
        refresh_start_i = 1'b0;
        wait_scan();
        check_scan(s, l0, s0, 0);
        check("ch0_on", 64'(ld_on[l0]), 64'h1234);
        check("ch0_off", 64'(ld_off[l0]), 64'h1678);
        check("ch3_on", 64'(ld_on[l0 + 3]), 64'h1F5A);
        check("ch3_off", 64'(ld_off[l0 + 3]), 64'h00C3);
        check("ch15_on", 64'(ld_on[l0 + 15]), 64'h0342);
        check("ch15_off", 64'(ld_off[l0 + 15]), 64'h0544);

        l0 = n_ld;
        s0 = n_st;
        start_scan(s);
        @(negedge clk);
        i2c_xfer(1'b1, 8'h80, 8'h5C, lat, rd);
        check("cont_lat", 64'(lat), 64'd4);
        check("cont_wr_cyc", 64'(st_cyc[s0 + 4]), 64'(s + 5));
        check("cont_wr_we", 64'(st_we[s0 + 4]), 64'd1);
        check("cont_wr_addr", 64'(st_addr[s0 + 4]), 64'h80);
        check("cont_wr_data", 64'(st_wd[s0 + 4]), 64'h5C);
        wait_scan();
        check_scan(s, l0, s0, 1);

        start_scan(s);
        repeat (9) @(negedge clk);
        rst_ni = 1'b0;
        #1;
        check("rst_mid_outs", 64'({i2c_bus.ack, i2c_bus.rdata, refresh_busy_o, ch_load_o, ch_idx_o, ch_on_o,
                                   ch_off_o, ram_en_o, ram_we_o, ram_addr_o, ram_wdata_o}), 64'd0);
        repeat (3) @(negedge clk);
        rst_ni = 1'b1;
        n1 = n_ld;
        repeat (10) @(negedge clk);
        check("no_load_after_rst", 64'(n_ld - n1), 64'd0);
        check("idle_after_rst", 64'(refresh_busy_o), 64'd0);
        l0 = n_ld;
        s0 = n_st;
        start_scan(s);
        wait_scan();
        check_scan(s, l0, s0, 0);

        s0 = n_st;
        t0 = cyc;
        i2c_xfer(1'b1, 8'h06, 8'hAB, lat, rd);
        check("wr_lat", 64'(lat), 64'd2);
        check("wr_strobes", 64'(n_st - s0), 64'd1);
        check("wr_cyc", 64'(st_cyc[s0]), 64'(t0 + 1));
        check("wr_we", 64'(st_we[s0]), 64'd1);
        check("wr_addr", 64'(st_addr[s0]), 64'h06);
        check("wr_data", 64'(st_wd[s0]), 64'hAB);
        s0 = n_st;
        t0 = cyc;
        i2c_xfer(1'b0, 8'h06, 8'h00, lat, rd);
        check("rd_lat", 64'(lat), 64'd3);
        check("rd_data", 64'(rd), 64'hAB);
        check("rd_strobes", 64'(n_st - s0), 64'd1);
        check("rd_cyc", 64'(st_cyc[s0]), 64'(t0 + 1));
        check("rd_we", 64'(st_we[s0]), 64'd0);
        repeat (3) @(negedge clk);
        check("rdata_hold", 64'(i2c_bus.rdata), 64'hAB);
        i2c_xfer(1'b0, 8'h80, 8'h00, lat, rd);
        check("rd80_lat", 64'(lat), 64'd3);
        check("rd80_data", 64'(rd), 64'h5C);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
